// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and a
// frame-length helper. Used by both the transmitter and the receiver.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit per frame
// (state encoding widens to 3 bits and gains PARITY).
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 16;
   localparam int DEFAULT_DATA_BITS    = 8;

`ifdef UART_TX_PARITY_EN
   localparam int STATE_W             = 3;
   // start + parity + stop
   localparam int FRAME_OVERHEAD_BITS = 3;
   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } uart_state_e;
`else
   localparam int STATE_W             = 2;
   // start + stop
   localparam int FRAME_OVERHEAD_BITS = 2;
   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;
`endif

   // Clock cycles from the first start-bit cycle back to IDLE.
   localparam int DEFAULT_FRAME_CYCLES =
      (FRAME_OVERHEAD_BITS + DEFAULT_DATA_BITS) * DEFAULT_CLKS_PER_BIT;

   function automatic int frame_cycles(input int clks_per_bit, input int data_bits);
      return (FRAME_OVERHEAD_BITS + data_bits) * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and emits a
// single-cycle tick on the terminal count, wrapping to zero. A synchronous
// clear holds it at zero (used to restart the period on state entry).
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = ena_i && (cnt_q == TERM);

   // Next count: clear wins, terminal count wraps, otherwise advance when enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (tick_o) begin
         cnt_d = '0;
      end else if (ena_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register, asynchronously reset to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit serializer. Accepts a byte over valid/ready and sends an
// 8N1 frame LSB-first on a registered tx line (idle high).
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 valid_in,
   output logic                 ready_out,
   output logic                 tx,
   output logic                 busy
);

   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

   uart_state_e          state_q;
   logic                 tx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [IW-1:0]        idx_q;
   logic                 tick;
   logic [DATA_BITS-1:0] shift_shr;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q;
`endif

   // The period counter idles at zero, so every frame starts a fresh period;
   // later state changes happen on the tick, where the counter wraps itself.
   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .ena_i (ena),
      .clr_i (state_q == IDLE),
      .tick_o(tick)
   );

   assign shift_shr = shift_q >> 1;
   assign ready_out = (state_q == IDLE) && ena && rst_n;
   assign busy      = (state_q != IDLE);
   assign tx        = tx_q;

   // Frame sequencer: tx is registered so each level appears the cycle after
   // the decision; everything freezes while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tx_q     <= 1'b1;
         shift_q  <= '0;
         idx_q    <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else if (ena) begin
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (valid_in) begin
                  shift_q  <= data_in;
                  idx_q    <= '0;
                  tx_q     <= 1'b0;
                  state_q  <= START;
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^data_in;
`endif
               end
            end
            START: begin
               if (tick) begin
                  tx_q    <= shift_q[0];
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  shift_q <= shift_shr;
                  if (idx_q == LAST_IDX) begin
                     idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
                     tx_q    <= parity_q;
                     state_q <= PARITY;
`else
                     tx_q    <= 1'b1;
                     state_q <= STOP;
`endif
                  end else begin
                     idx_q <= idx_q + IW'(1);
                     tx_q  <= shift_shr[0];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  tx_q    <= 1'b1;
                  state_q <= STOP;
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  tx_q    <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter: a frame-level model (a queue of expected tx
// levels per cycle) is compared with the DUT every cycle, plus literal
// expectations for directed scenarios. Honours UART_TX_PARITY_EN.
module tb_uart_transmitter;

   localparam int C = 4;
   localparam int D = 8;
`ifdef UART_TX_PARITY_EN
   localparam int NB        = 3 + D;
   localparam bit PAR       = 1'b1;
   localparam int EXP_FRAME = 44;
   localparam logic [15:0] EXP_A5_LEVELS = 16'h054A;
`else
   localparam int NB        = 2 + D;
   localparam bit PAR       = 1'b0;
   localparam int EXP_FRAME = 40;
   localparam logic [15:0] EXP_A5_LEVELS = 16'h034A;
`endif
   localparam int FL = NB * C;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       valid_in = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       ready_out;
   logic       tx;
   logic       busy;

   uart_transmitter #(
      .CLKS_PER_BIT(C),
      .DATA_BITS   (D)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .data_in  (data_in),
      .valid_in (valid_in),
      .ready_out(ready_out),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   bit mq[$];
   bit m_tx = 1'b1;
   bit m_busy = 1'b0;

   function automatic void push_frame(input logic [7:0] b);
      for (int c = 0; c < C; c++) mq.push_back(1'b0);
      for (int k = 0; k < D; k++)
         for (int c = 0; c < C; c++) mq.push_back(b[k]);
      if (PAR)
         for (int c = 0; c < C; c++) mq.push_back(^b);
      for (int c = 0; c < C; c++) mq.push_back(1'b1);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_tx   = 1'b1;
         m_busy = 1'b0;
      end else if (ena) begin
         if (!m_busy && valid_in) begin
            push_frame(data_in);
            m_tx   = mq.pop_front();
            m_busy = 1'b1;
         end else if (mq.size() > 0) begin
            m_tx   = mq.pop_front();
            m_busy = 1'b1;
         end else begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("tx", tx, m_tx);
         chk("busy", busy, m_busy);
         chk("ready_out", ready_out, (!m_busy && ena && rst_n));
      end
   end

   // ---------------- recorder for directed literal checks ----------------
   bit trace[$];
   int busy_cnt = 0;
   bit rec = 1'b0;

   always @(negedge clk) begin
      if (rec) begin
         if (ena) trace.push_back(tx);
         if (busy) busy_cnt++;
      end
   end

   task automatic start_rec();
      trace.delete();
      busy_cnt = 0;
      rec = 1'b1;
   endtask

   function automatic logic [7:0] decode(input int s);
      logic [7:0] r;
      r = 'x;
      for (int k = 0; k < 8; k++) begin
         int idx;
         idx = s + C * (k + 1) + 1;
         if (idx < trace.size()) r[k] = trace[idx];
      end
      return r;
   endfunction

   task automatic wait_ready();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (ready_out === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("wait_ready_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("wait_idle_timeout", 0, 1);
   endtask

   // Returns at posedge+2 of the accepting edge.
   task automatic send(input logic [7:0] b);
      data_in  = b;
      valid_in = 1'b1;
      wait_ready();
      @(posedge clk);
      #2;
      valid_in = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int g;
      logic [15:0] lv;

      repeat (3) @(posedge clk);
      chk_en = 1'b1;
      #2;
      rst_n = 1'b1;
      ena   = 1'b1;

      // Reset idle: 100 quiet cycles.
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || ready_out !== 1'b1) bad++;
      end
      chk("idle_hold_bad_cycles", bad, 0);
      @(posedge clk);
      #2;

      // Single byte 0xA5.
      send(8'hA5);
      start_rec();
      wait_idle();
      lv = '0;
      for (int k = 0; k < NB; k++) lv[k] = trace[k * C + 1];
      chk("a5_levels", lv, EXP_A5_LEVELS);
      chk("a5_busy_cycles", busy_cnt, EXP_FRAME);
      chk("a5_ready_after", ready_out, 1);
      rec = 1'b0;
      @(posedge clk);
      #2;

      // Back-to-back 0x00 then 0xFF with valid held.
      data_in  = 8'h00;
      valid_in = 1'b1;
      wait_ready();
      @(posedge clk);
      #2;
      start_rec();
      data_in = 8'hFF;
      wait_ready();
      @(posedge clk);
      #2;
      valid_in = 1'b0;
      wait_idle();
      g = 0;
      for (int i = FL - C; i < trace.size(); i++) begin
         if (trace[i] != 1'b1) break;
         g++;
      end
      chk("b2b_gap_high_cycles", g, C + 1);
      chk("b2b_byte0", decode(0), 8'h00);
      chk("b2b_byte1", decode(FL + 1), 8'hFF);
      rec = 1'b0;
      @(posedge clk);
      #2;

      // ena pause during data bit 3 of 0x3C.
      send(8'h3C);
      start_rec();
      repeat (17) @(posedge clk);
      #2;
      ena = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      ena = 1'b1;
      wait_idle();
      chk("pause_busy_cycles", busy_cnt, EXP_FRAME + 7);
      chk("pause_byte", decode(0), 8'h3C);
      rec = 1'b0;
      @(posedge clk);
      #2;

      // Reset during data bit 5 of 0x5A (tx low there), then send 0x81.
      send(8'h5A);
      repeat (25) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_tx_async", tx, 1);
      chk("rst_busy", busy, 0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      send(8'h81);
      start_rec();
      wait_idle();
      chk("post_rst_byte", decode(0), 8'h81);
      chk("post_rst_busy_cycles", busy_cnt, EXP_FRAME);
      rec = 1'b0;
      @(posedge clk);
      #2;

`ifdef UART_TX_PARITY_EN
      send(8'h07);
      start_rec();
      wait_idle();
      chk("par07_busy_cycles", busy_cnt, 44);
      chk("par07_bit", trace[9 * C + 1], 1);
      rec = 1'b0;
      @(posedge clk);
      #2;
      send(8'h03);
      start_rec();
      wait_idle();
      chk("par03_bit", trace[9 * C + 1], 0);
      rec = 1'b0;
      @(posedge clk);
      #2;
`endif

      // Randomized traffic: random valid, data changing every cycle, ena gaps.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         valid_in = ($urandom_range(0, 3) != 0);
         data_in  = 8'($urandom);
         ena      = ($urandom_range(0, 7) != 0);
      end
      valid_in = 1'b0;
      ena      = 1'b1;
      wait_idle();
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
